glb_arbiter: RTL and testbench

Shares the single GLB SRAM port (byte-enabled 32-bit write, registered 32-bit read with one-cycle latency) among `NUM_REQ` requesters, e.g. DMA fill, PE-array ifmap/weight read, psum write-back. Round-robin arbitration per transaction, with burst locking so a requester can stream consecutive beats without interleaving. Read data is routed back to the issuing requester one cycle after acceptance. Sits between the GLB instance and the dataflow/DMA controllers.

---
 rtl/glb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/glb_arbiter.sv | 116 +++++++++++
 tb/tb_glb_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/glb_pkg.sv
// glb_pkg: shared GLB port widths, arbiter state encoding and requester IDs
package glb_pkg;

    localparam int GLB_ADDR_W = 16;
    localparam int GLB_DATA_W = 32;
    localparam int GLB_BE_W   = GLB_DATA_W / 8;

    localparam int REQ_DMA  = 0;
    localparam int REQ_PE   = 1;
    localparam int REQ_PSUM = 2;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: cyclic priority picker, first request at or after ptr_i wins
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] j;

    // Scan from the farthest offset to the nearest so the closest request to ptr wins
    always_comb begin
        idx_o = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (req_i[j]) idx_o = j;
        end
    end

    assign any_o = |req_i;
    assign gnt_o = any_o ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/glb_arbiter.sv
// glb_arbiter: round-robin, burst-locking arbiter for the GLB SRAM port (GLB_ARB_FIXED_PRIO_EN gives requester 0 priority in IDLE)
module glb_arbiter
    import glb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = GLB_ADDR_W,
    parameter int DATA_W    = GLB_DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic [DATA_W/8-1:0]           glb_w_en,
    output logic [ADDR_W-1:0]             glb_address,
    output logic [DATA_W-1:0]             glb_write_data,
    input  logic [DATA_W-1:0]             glb_read_data,
    output logic                          busy
);

    localparam int BE_W = DATA_W / 8;
    localparam int IW   = $clog2(NUM_REQ);
    localparam int CW   = $clog2(MAX_BURST + 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0] arb_req, arb_gnt;
    logic [IW-1:0]      arb_idx, win, nxt_ptr;
    logic               arb_any, lock, gnt, rls;
    logic [BE_W-1:0]    win_we;
    logic [CW-1:0]      rel_cnt;

    assign lock = state_q == LOCK;

`ifdef GLB_ARB_FIXED_PRIO_EN
    // Requester 0 pre-empts the ring only when no burst is locked
    assign arb_req = lock ? '0 : (req_valid[0] ? NUM_REQ'(1) : {req_valid[NUM_REQ-1:1], 1'b0});
`else
    assign arb_req = lock ? '0 : req_valid;
`endif

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req_i (arb_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign win       = lock ? owner_q : arb_idx;
    assign gnt       = lock ? req_valid[owner_q] : arb_any;
    assign req_ready = lock ? (gnt ? NUM_REQ'(1) << owner_q : '0) : arb_gnt;
    assign win_we    = req_we[int'(win)*BE_W +: BE_W];

    assign glb_w_en       = gnt ? win_we : '0;
    assign glb_address    = gnt ? req_addr[int'(win)*ADDR_W +: ADDR_W] : '0;
    assign glb_write_data = gnt ? req_wdata[int'(win)*DATA_W +: DATA_W] : '0;

    // Beat count after this beat: a fresh burst starts at 1
    assign rel_cnt = lock ? beat_cnt_q + CW'(1) : CW'(1);
    assign rls     = gnt & (req_last[win] | rel_cnt == CW'(MAX_BURST));
    assign nxt_ptr = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);

    // Next-state: release advances the ring past the winner, otherwise lock onto it
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        rsp_valid_d = (gnt && win_we == '0) ? NUM_REQ'(1) << win : '0;
        if (rls) begin
            state_d    = IDLE;
            rr_ptr_d   = nxt_ptr;
            beat_cnt_d = '0;
        end else if (gnt) begin
            state_d    = LOCK;
            owner_d    = win;
            beat_cnt_d = rel_cnt;
        end
    end

    // FSM and response-tag registers; reset drops any lock and pending response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = glb_read_data;
    assign busy      = lock | (|rsp_valid_q);

endmodule

// File: tb/tb_glb_arbiter.sv
// tb_glb_arbiter: scoreboard bench for glb_arbiter with a byte-enabled GLB memory model
module tb_glb_arbiter;

`ifdef GLB_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [11:0] req_we = '0;
    logic [47:0] req_addr = '0;
    logic [95:0] req_wdata = '0;
    logic [2:0]  req_last = '0;
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [3:0]  glb_w_en;
    logic [15:0] glb_address;
    logic [31:0] glb_write_data;
    logic [31:0] glb_read_data;
    logic        busy;

    glb_arbiter #(
        .NUM_REQ   (3),
        .ADDR_W    (16),
        .DATA_W    (32),
        .MAX_BURST (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_last       (req_last),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .glb_w_en       (glb_w_en),
        .glb_address    (glb_address),
        .glb_write_data (glb_write_data),
        .glb_read_data  (glb_read_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic [31:0] wtmp;
    initial for (int i = 0; i < 256; i++) mem[i] = '0;

    // GLB model: byte-enabled write, registered read of the driven address
    always @(posedge clk) begin
        wtmp = mem[glb_address[9:2]];
        for (int b = 0; b < 4; b++) if (glb_w_en[b]) wtmp[8*b +: 8] = glb_write_data[8*b +: 8];
        if (|glb_w_en) mem[glb_address[9:2]] <= wtmp;
        glb_read_data <= mem[glb_address[9:2]];
    end

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t         sbq[$];
    sb_t         e;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_rd [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitor: each accepted read must return exactly one cycle later
    always @(negedge clk) begin
        if (!rst) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                check("rsp_id", rsp_valid, 64'(3'b001 << e.id));
                check("rsp_data", rsp_rdata, e.data);
            end else if (rsp_valid != '0) begin
                check("rsp_unexp", rsp_valid, 0);
            end
        end
    end

    task automatic set_req(input int r, input logic v, input logic [3:0] we, input logic [15:0] a,
                           input logic [31:0] d, input logic l);
        req_valid[r]         = v;
        req_we[r*4 +: 4]     = we;
        req_addr[r*16 +: 16] = a;
        req_wdata[r*32 +: 32] = d;
        req_last[r]          = l;
    endtask

    task automatic clr_all();
        for (int r = 0; r < 3; r++) set_req(r, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
    endtask

    // One bus cycle: check grant, GLB drive and optionally busy; log expected reads
    task automatic cycle(input string tag, input logic [2:0] exp_rdy, input int exp_busy);
        int w;
        @(negedge clk);
        w = -1;
        for (int r = 0; r < 3; r++) if (exp_rdy[r]) w = r;
        check(tag, req_ready, exp_rdy);
        check({tag, "_we"}, glb_w_en, (w < 0) ? 0 : req_we[w*4 +: 4]);
        check({tag, "_addr"}, glb_address, (w < 0) ? 0 : req_addr[w*16 +: 16]);
        check({tag, "_wd"}, glb_write_data, (w < 0) ? 0 : req_wdata[w*32 +: 32]);
        if (exp_busy >= 0) check({tag, "_busy"}, busy, 64'(exp_busy));
        if (w >= 0 && req_we[w*4 +: 4] == 4'h0) sbq.push_back('{id: w, data: exp_rd[w], due: cyc + 1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int r = 0; r < 3; r++) exp_rd[r] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cycle("rst_idle", 3'b000, 0);
        check("rst_rsp", rsp_valid, 0);

        // Reset in the middle of a lock with a read accepted in the reset cycle
        set_req(1, 1'b1, 4'h0, 16'h0040, 32'h0, 1'b0);
        cycle("lock_b1", 3'b010, 0);
        set_req(1, 1'b0, 4'h0, 16'h0040, 32'h0, 1'b0);
        cycle("lock_bub", 3'b000, 1);
        set_req(0, 1'b1, 4'h0, 16'h0040, 32'h0, 1'b1);
        set_req(1, 1'b1, 4'h0, 16'h0040, 32'h0, 1'b0);
        set_req(2, 1'b1, 4'h0, 16'h0040, 32'h0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        set_req(1, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        cycle("post_rst", 3'b001, 0);
        clr_all();

        // Write then read-after-write from another requester
        set_req(0, 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, 1'b1);
        cycle("wr_dead", 3'b001, 1);
        clr_all();
        set_req(1, 1'b1, 4'h0, 16'h0010, 32'h0, 1'b1);
        exp_rd[1] = 32'hDEADBEEF;
        cycle("rd_dead", 3'b010, -1);
        clr_all();
        set_req(2, 1'b1, 4'hF, 16'h0020, 32'h11223344, 1'b1);
        cycle("wr_full", 3'b100, 1);
        clr_all();

        // Three single-beat readers held valid
        for (int r = 0; r < 3; r++) set_req(r, 1'b1, 4'h0, 16'h0040, 32'h0, 1'b1);
        exp_rd[0] = '0; exp_rd[1] = '0; exp_rd[2] = '0;
        for (int i = 0; i < 6; i++) cycle("rr", FIXED ? 3'b001 : 3'(3'b001 << (i % 3)), -1);
        clr_all();
        cycle("idle1", 3'b000, 1);

        // Locked 4-beat read burst with a 2-cycle bubble
        exp_rd[1] = 32'hDEADBEEF;
        set_req(1, 1'b1, 4'h0, 16'h0010, 32'h0, 1'b0);
        cycle("bst_b1", 3'b010, 0);
        set_req(0, 1'b1, 4'h0, 16'h0040, 32'h0, 1'b1);
        set_req(2, 1'b1, 4'h0, 16'h0040, 32'h0, 1'b1);
        cycle("bst_b2", 3'b010, 1);
        req_valid[1] = 1'b0;
        cycle("bst_bub", 3'b000, 1);
        cycle("bst_bub", 3'b000, 1);
        req_valid[1] = 1'b1;
        cycle("bst_b3", 3'b010, 1);
        req_last[1] = 1'b1;
        cycle("bst_b4", 3'b010, 1);
        set_req(1, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        cycle("bst_next", FIXED ? 3'b001 : 3'b100, 1);
        clr_all();
        cycle("idle2", 3'b000, -1);

        // 20-beat write stream is cut at MAX_BURST and re-arbitrates
        set_req(2, 1'b1, 4'hF, 16'h0080, 32'd1, 1'b0);
        cycle("mb_1", 3'b100, -1);
        set_req(0, 1'b1, 4'h0, 16'h0040, 32'h0, 1'b1);
        exp_rd[0] = '0;
        for (int b = 2; b <= 16; b++) begin
            set_req(2, 1'b1, 4'hF, 16'(16'h0080 + 4 * b), 32'(b), 1'b0);
            cycle("mb_lock", 3'b100, 1);
        end
        set_req(2, 1'b1, 4'hF, 16'h00C4, 32'd17, 1'b0);
        cycle("mb_rel", 3'b001, 0);
        set_req(0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        for (int b = 17; b <= 20; b++) begin
            set_req(2, 1'b1, 4'hF, 16'(16'h0080 + 4 * b), 32'(b), b == 20);
            cycle("mb_res", 3'b100, -1);
        end
        clr_all();

        // Partial byte write merges into the earlier full word
        set_req(0, 1'b1, 4'h4, 16'h0020, 32'h00AA0000, 1'b1);
        cycle("wr_part", 3'b001, -1);
        set_req(0, 1'b1, 4'h0, 16'h0020, 32'h0, 1'b1);
        exp_rd[0] = 32'h11AA3344;
        cycle("rd_part", 3'b001, -1);
        clr_all();
        repeat (3) cycle("drain", 3'b000, -1);
        check("sb_drain", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
